// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, 64-bit ALU, iterative shift-add multiplier
// and the EX/MEM pipeline register.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [63:0] pc_in,
    input  logic [63:0] reg_data1_in,
    input  logic [63:0] reg_data2_in,
    input  logic [63:0] imm_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    input  logic [6:0]  funct7_in,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        ALUSrc_in,
    input  logic [1:0]  ALUOp_in,
    input  logic [1:0]  forwardA,
    input  logic [1:0]  forwardB,
    input  logic [63:0] exmem_fwd_data,
    input  logic [63:0] memwb_fwd_data,
    output logic [63:0] alu_result_out,
    output logic [63:0] store_data_out,
    output logic [63:0] branch_target_out,
    output logic [4:0]  rd_out,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        zero_out,
    output logic        stall_out
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_e;

    mul_state_e  state_q, state_d;
    logic [63:0] mul_a_q, mul_a_d;
    logic [63:0] mul_b_q, mul_b_d;
    logic [63:0] acc_q, acc_d;
    logic [6:0]  count_q, count_d;

    logic [63:0] alu_result_q, alu_result_d;
    logic [63:0] store_data_q, store_data_d;
    logic [63:0] branch_target_q, branch_target_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        zero_q, zero_d;

    logic [63:0] op_a, b_fwd, op_b;
    logic [63:0] alu_res, ex_res;
    logic [5:0]  shamt;
    logic        is_mul;
    logic        stall;

    always_comb begin
        case (forwardA)
            2'b10:   op_a = exmem_fwd_data;
            2'b01:   op_a = memwb_fwd_data;
            default: op_a = reg_data1_in;
        endcase
        case (forwardB)
            2'b10:   b_fwd = exmem_fwd_data;
            2'b01:   b_fwd = memwb_fwd_data;
            default: b_fwd = reg_data2_in;
        endcase
        op_b  = ALUSrc_in ? imm_in : b_fwd;
        shamt = op_b[5:0];
    end

    always_comb begin
        alu_res = op_a + op_b;
        case (ALUOp_in)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b10: begin
                case (funct3_in)
                    3'b000: alu_res = (funct7_in[5] && !ALUSrc_in) ?
                                      op_a - op_b : op_a + op_b;
                    3'b001: alu_res = op_a << shamt;
                    3'b010: alu_res = {63'd0, $signed(op_a) < $signed(op_b)};
                    3'b011: alu_res = {63'd0, op_a < op_b};
                    3'b100: alu_res = op_a ^ op_b;
                    3'b101: alu_res = funct7_in[5] ?
                                      $unsigned($signed(op_a) >>> shamt) :
                                      op_a >> shamt;
                    3'b110: alu_res = op_a | op_b;
                    default: alu_res = op_a & op_b;
                endcase
            end
            default: alu_res = op_a + op_b;
        endcase
    end

    assign is_mul = (ALUOp_in == 2'b10) && !ALUSrc_in &&
                    (funct7_in == 7'b0000001) && (funct3_in == 3'b000);

    // One shift-add step per BUSY cycle: A shifts left, B shifts right.
    always_comb begin
        state_d = state_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        acc_d   = acc_q;
        count_d = count_q;
        stall   = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_mul) begin
                        mul_a_d = op_a;
                        mul_b_d = op_b;
                        acc_d   = 64'd0;
                        count_d = 7'd0;
                        state_d = BUSY;
                        stall   = 1'b1;
                    end
                end
                BUSY: begin
                    acc_d   = acc_q + (mul_b_q[0] ? mul_a_q : 64'd0);
                    mul_a_d = mul_a_q << 1;
                    mul_b_d = mul_b_q >> 1;
                    count_d = count_q + 7'd1;
                    stall   = 1'b1;
                    if (count_q == 7'd63) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign stall_out = stall && !reset;
    assign ex_res    = (state_q == DONE) ? acc_q : alu_res;

    always_comb begin
        alu_result_d    = 64'd0;
        store_data_d    = 64'd0;
        branch_target_d = 64'd0;
        rd_d            = 5'd0;
        reg_write_d     = 1'b0;
        mem_to_reg_d    = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        zero_d          = 1'b0;
        if (!flush && !stall) begin
            alu_result_d    = ex_res;
            store_data_d    = b_fwd;
            branch_target_d = pc_in + imm_in;
            rd_d            = rd_in;
            reg_write_d     = RegWrite_in;
            mem_to_reg_d    = MemtoReg_in;
            mem_read_d      = MemRead_in;
            mem_write_d     = MemWrite_in;
            zero_d          = (ex_res == 64'd0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            mul_a_q         <= 64'd0;
            mul_b_q         <= 64'd0;
            acc_q           <= 64'd0;
            count_q         <= 7'd0;
            alu_result_q    <= 64'd0;
            store_data_q    <= 64'd0;
            branch_target_q <= 64'd0;
            rd_q            <= 5'd0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            zero_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            mul_a_q         <= mul_a_d;
            mul_b_q         <= mul_b_d;
            acc_q           <= acc_d;
            count_q         <= count_d;
            alu_result_q    <= alu_result_d;
            store_data_q    <= store_data_d;
            branch_target_q <= branch_target_d;
            rd_q            <= rd_d;
            reg_write_q     <= reg_write_d;
            mem_to_reg_q    <= mem_to_reg_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            zero_q          <= zero_d;
        end
    end

    assign alu_result_out    = alu_result_q;
    assign store_data_out    = store_data_q;
    assign branch_target_out = branch_target_q;
    assign rd_out            = rd_q;
    assign RegWrite_out      = reg_write_q;
    assign MemtoReg_out      = mem_to_reg_q;
    assign MemRead_out       = mem_read_q;
    assign MemWrite_out      = mem_write_q;
    assign zero_out          = zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed scenarios plus randomized ALU traffic
// compared against a behavioural reference.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [63:0] pc_in, reg_data1_in, reg_data2_in, imm_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic [6:0]  funct7_in;
    logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, ALUSrc_in;
    logic [1:0]  ALUOp_in, forwardA, forwardB;
    logic [63:0] exmem_fwd_data, memwb_fwd_data;
    logic [63:0] alu_result_out, store_data_out, branch_target_out;
    logic [4:0]  rd_out;
    logic        RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;
    logic        zero_out, stall_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .pc_in(pc_in), .reg_data1_in(reg_data1_in),
        .reg_data2_in(reg_data2_in), .imm_in(imm_in),
        .rd_in(rd_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .ALUSrc_in(ALUSrc_in), .ALUOp_in(ALUOp_in),
        .forwardA(forwardA), .forwardB(forwardB),
        .exmem_fwd_data(exmem_fwd_data), .memwb_fwd_data(memwb_fwd_data),
        .alu_result_out(alu_result_out), .store_data_out(store_data_out),
        .branch_target_out(branch_target_out), .rd_out(rd_out),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .zero_out(zero_out), .stall_out(stall_out)
    );

    function automatic logic [63:0] ref_alu(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [1:0] op,
                                            input logic [2:0] f3,
                                            input logic [6:0] f7,
                                            input logic src);
        logic [5:0] sh;
        logic signed [63:0] sa;
        sh = b[5:0];
        sa = a;
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (f3)
            3'd0: return (f7[5] && !src) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3: return (a < b) ? 64'd1 : 64'd0;
            3'd4: return a ^ b;
            3'd5: return f7[5] ? 64'(sa >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [63:0] sel(input logic [1:0] f,
                                        input logic [63:0] r);
        if (f == 2'b10) return exmem_fwd_data;
        if (f == 2'b01) return memwb_fwd_data;
        return r;
    endfunction

    task automatic set_idle();
        flush = 0; pc_in = 0; reg_data1_in = 0; reg_data2_in = 0; imm_in = 0;
        rd_in = 0; funct3_in = 0; funct7_in = 0;
        RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
        ALUSrc_in = 0; ALUOp_in = 0; forwardA = 0; forwardB = 0;
        exmem_fwd_data = 0; memwb_fwd_data = 0;
    endtask

    task automatic set_rtype(input logic [63:0] a, input logic [63:0] b,
                             input logic [2:0] f3, input logic [6:0] f7);
        set_idle();
        reg_data1_in = a; reg_data2_in = b;
        funct3_in = f3; funct7_in = f7; ALUOp_in = 2'b10;
        RegWrite_in = 1; rd_in = 5'd9;
    endtask

    task automatic test_reset();
        reset = 1;
        set_rtype(64'd5, 64'd7, 3'd0, 7'd0);
        #3;
        n_tests++;
        if (alu_result_out !== 0 || RegWrite_out !== 0 || rd_out !== 0 ||
            store_data_out !== 0 || branch_target_out !== 0 || zero_out !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: got res=%h rw=%b rd=%0d, required all 0",
                     alu_result_out, RegWrite_out, rd_out);
        end
        set_rtype(64'd6, 64'd7, 3'd0, 7'd1);
        #1;
        n_tests++;
        if (stall_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b, required 0", stall_out);
        end
    endtask

    task automatic test_add();
        @(negedge clk);
        reset = 0;
        set_rtype(64'd5, 64'd7, 3'd0, 7'd0);
        rd_in = 5'd3;
        @(posedge clk); #1;
        n_tests++;
        if (alu_result_out !== 64'd12 || rd_out !== 5'd3 ||
            RegWrite_out !== 1'b1 || zero_out !== 1'b0) begin
            n_fail++;
            $display("FAIL add: got res=%0d rd=%0d rw=%b z=%b, required 12 3 1 0",
                     alu_result_out, rd_out, RegWrite_out, zero_out);
        end
    endtask

    task automatic test_forward();
        @(negedge clk);
        set_idle();
        forwardA = 2'b10; exmem_fwd_data = 64'd100; reg_data1_in = 64'd55;
        ALUSrc_in = 1; imm_in = '1; reg_data2_in = 64'hABCD; MemWrite_in = 1;
        @(posedge clk); #1;
        n_tests++;
        if (alu_result_out !== 64'd99 || store_data_out !== 64'hABCD ||
            MemWrite_out !== 1'b1) begin
            n_fail++;
            $display("FAIL forward: got res=%0d st=%h mw=%b, required 99 abcd 1",
                     alu_result_out, store_data_out, MemWrite_out);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        set_idle();
        ALUOp_in = 2'b01; reg_data1_in = 64'd42; reg_data2_in = 64'd42;
        pc_in = 64'h1000; imm_in = 64'h20;
        @(posedge clk); #1;
        n_tests++;
        if (zero_out !== 1'b1 || branch_target_out !== 64'h1020) begin
            n_fail++;
            $display("FAIL branch: got z=%b tgt=%h, required 1 1020",
                     zero_out, branch_target_out);
        end
    endtask

    task automatic test_mul(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] expect_p);
        int n;
        int bad;
        n = 0;
        bad = 0;
        @(negedge clk);
        set_rtype(64'd0, b, 3'd0, 7'd1);
        forwardA = 2'b10; exmem_fwd_data = a; rd_in = 5'd17;
        #1;
        while (stall_out === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
            if (RegWrite_out !== 0 || alu_result_out !== 0 || rd_out !== 0)
                bad++;
            exmem_fwd_data = {$urandom, $urandom};
            @(negedge clk); #1;
        end
        n_tests++;
        if (n != 65) begin
            n_fail++;
            $display("FAIL mul_stall_len: got %0d cycles, required 65", n);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mul_bubble: got %0d non-bubble cycles, required 0", bad);
        end
        @(posedge clk); #1;
        n_tests++;
        if (alu_result_out !== expect_p || RegWrite_out !== 1'b1 ||
            rd_out !== 5'd17) begin
            n_fail++;
            $display("FAIL mul_result: got %h rw=%b rd=%0d, required %h 1 17",
                     alu_result_out, RegWrite_out, rd_out, expect_p);
        end
    endtask

    task automatic test_flush_mid_mul();
        @(negedge clk);
        set_rtype(64'd123, 64'd456, 3'd0, 7'd1);
        repeat (21) @(posedge clk);
        @(negedge clk);
        flush = 1;
        #1;
        n_tests++;
        if (stall_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: got %b, required 0", stall_out);
        end
        @(posedge clk); #1;
        n_tests++;
        if (RegWrite_out !== 0 || alu_result_out !== 0) begin
            n_fail++;
            $display("FAIL flush_bubble: got rw=%b res=%h, required 0 0",
                     RegWrite_out, alu_result_out);
        end
        @(negedge clk);
        set_rtype(64'd1, 64'd2, 3'd0, 7'd0);
        #1;
        n_tests++;
        if (stall_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: got stall %b, required 0", stall_out);
        end
        @(posedge clk); #1;
        n_tests++;
        if (alu_result_out !== 64'd3) begin
            n_fail++;
            $display("FAIL flush_next_op: got %0d, required 3", alu_result_out);
        end
        test_mul(64'd6, 64'd7, 64'd42);
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        set_rtype(64'd5, 64'd7, 3'd0, 7'd0);
        @(posedge clk); #2;
        reset = 1;
        #1;
        n_tests++;
        if (alu_result_out !== 0 || RegWrite_out !== 0) begin
            n_fail++;
            $display("FAIL reset_async: got res=%h rw=%b, required 0 0",
                     alu_result_out, RegWrite_out);
        end
        @(negedge clk);
        reset = 0;
        set_rtype(64'd9, 64'd9, 3'd0, 7'd1);
        repeat (10) @(posedge clk);
        #2;
        reset = 1;
        #1;
        n_tests++;
        if (stall_out !== 0 || alu_result_out !== 0 || RegWrite_out !== 0) begin
            n_fail++;
            $display("FAIL reset_busy: got stall=%b res=%h, required 0 0",
                     stall_out, alu_result_out);
        end
        @(negedge clk);
        reset = 0;
        set_rtype(64'h8000000000000000, 64'd4, 3'd5, 7'h20);
        #1;
        n_tests++;
        if (stall_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fsm_idle: got stall %b, required 0", stall_out);
        end
        @(posedge clk); #1;
        n_tests++;
        if (alu_result_out !== 64'hF800000000000000) begin
            n_fail++;
            $display("FAIL sra_after_reset: got %h, required f800000000000000",
                     alu_result_out);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, bf, b, res, tgt;
        logic        fl;
        int          bad_res, bad_ctl, bad_stall;
        bad_res = 0; bad_ctl = 0; bad_stall = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            pc_in = {$urandom, $urandom};
            reg_data1_in = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9))
                                                       : {$urandom, $urandom};
            reg_data2_in = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9))
                                                       : {$urandom, $urandom};
            imm_in = {$urandom, $urandom};
            exmem_fwd_data = {$urandom, $urandom};
            memwb_fwd_data = {$urandom, $urandom};
            forwardA = 2'($urandom); forwardB = 2'($urandom);
            ALUOp_in = 2'($urandom); ALUSrc_in = 1'($urandom);
            funct3_in = 3'($urandom);
            case ($urandom_range(0, 3))
                0: funct7_in = 7'h00;
                1: funct7_in = 7'h20;
                2: funct7_in = 7'h01;
                default: funct7_in = 7'($urandom);
            endcase
            if (ALUOp_in == 2'b10 && !ALUSrc_in && funct7_in == 7'h01 &&
                funct3_in == 3'd0)
                funct7_in = 7'h00;
            rd_in = 5'($urandom);
            RegWrite_in = 1'($urandom); MemtoReg_in = 1'($urandom);
            MemRead_in = 1'($urandom); MemWrite_in = 1'($urandom);
            fl = ($urandom_range(0, 7) == 0);
            flush = fl;
            a  = sel(forwardA, reg_data1_in);
            bf = sel(forwardB, reg_data2_in);
            b  = ALUSrc_in ? imm_in : bf;
            res = ref_alu(a, b, ALUOp_in, funct3_in, funct7_in, ALUSrc_in);
            tgt = pc_in + imm_in;
            #1;
            if (stall_out !== 1'b0) bad_stall++;
            @(posedge clk); #1;
            if (fl) begin
                if (alu_result_out !== 0 || store_data_out !== 0 ||
                    branch_target_out !== 0 || zero_out !== 0)
                    bad_res++;
                if (RegWrite_out !== 0 || MemtoReg_out !== 0 ||
                    MemRead_out !== 0 || MemWrite_out !== 0 || rd_out !== 0)
                    bad_ctl++;
            end else begin
                if (alu_result_out !== res || store_data_out !== bf ||
                    branch_target_out !== tgt || zero_out !== (res == 0)) begin
                    bad_res++;
                    if (bad_res <= 3)
                        $display("FAIL rand_result: got %h, required %h (op=%0d f3=%0d f7=%h)",
                                 alu_result_out, res, ALUOp_in, funct3_in, funct7_in);
                end
                if (RegWrite_out !== RegWrite_in || MemtoReg_out !== MemtoReg_in ||
                    MemRead_out !== MemRead_in || MemWrite_out !== MemWrite_in ||
                    rd_out !== rd_in)
                    bad_ctl++;
            end
        end
        flush = 0;
        n_tests++;
        if (bad_res != 0) begin
            n_fail++;
            $display("FAIL rand_data: got %0d bad cycles, required 0", bad_res);
        end
        n_tests++;
        if (bad_ctl != 0) begin
            n_fail++;
            $display("FAIL rand_ctrl: got %0d bad cycles, required 0", bad_ctl);
        end
        n_tests++;
        if (bad_stall != 0) begin
            n_fail++;
            $display("FAIL rand_stall: got %0d stalled cycles, required 0", bad_stall);
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_add();
        test_forward();
        test_branch();
        test_mul(64'hFFFFFFFFFFFFFFFF, 64'd3, 64'hFFFFFFFFFFFFFFFD);
        test_mul(64'h0000_0001_2345_6789, 64'h0000_0000_9ABC_DEF1,
                 64'h0000_0001_2345_6789 * 64'h0000_0000_9ABC_DEF1);
        test_flush_mid_mul();
        test_reset_mid_mul();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
